// File: rtl/des_key_pkg.sv
// Shared definitions for DES key file handling: key width, the ASCII codes used
// in the hex key file format, and the writer FSM state type.
package des_key_pkg;

   localparam int unsigned KEY_W = 56;

   localparam logic [7:0] ASCII_NL = 8'h0A;
   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_LA = 8'h61;
   localparam logic [7:0] ASCII_UA = 8'h41;

   typedef enum logic [1:0] {
      StIdle,
      StHex,
      StNl,
      StFin
   } state_e;

endpackage

// File: rtl/key_hex_writer_if.sv
// Byte stream carrying the ASCII key text out of the writer (valid/ready).
//   out_data  - ASCII byte
//   out_valid - out_data is valid
//   out_ready - sink accepts the byte when out_valid && out_ready
//   out_last  - marks the final byte of a frame
interface key_hex_writer_if;

   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;

   modport master (
      output out_data,
      output out_valid,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_last,
      output out_ready
   );

endinterface

// File: rtl/hex_ascii_enc.sv
// Combinational nibble to ASCII hex digit encoder.
//   nib_i   - 4-bit value
//   upper_i - 1 selects 'A'-'F', 0 selects 'a'-'f' for values 10-15
//   ascii_o - ASCII character
module hex_ascii_enc
   import des_key_pkg::*;
(
   input  logic [3:0] nib_i,
   input  logic       upper_i,
   output logic [7:0] ascii_o
);

   always_comb begin
      ascii_o = ASCII_0 + {4'h0, nib_i};
      if (nib_i > 4'd9) begin
         ascii_o = (upper_i ? ASCII_UA : ASCII_LA) + {4'h0, nib_i} - 8'd10;
      end
   end

endmodule

// File: rtl/key_hex_writer.sv
// Serialises two keys as ASCII hex text, MSB nibble first, each key followed by
// a newline; key1 first, then key2.
//   clk, rst_n   - clock, asynchronous active-low reset
//   start_i      - request a frame; only honoured while idle
//   key1_i/key2_i- keys, captured when start is accepted
//   out_if       - byte stream (master side)
//   busy_o       - frame in progress (cycle after start until last byte taken)
//   done_o       - one-cycle pulse after the last byte is taken
module key_hex_writer
   import des_key_pkg::*;
#(
   parameter int unsigned KEY_W     = des_key_pkg::KEY_W,
   parameter bit          UPPERCASE = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [KEY_W-1:0] key1_i,
   input  logic [KEY_W-1:0] key2_i,
   key_hex_writer_if.master out_if,
   output logic             busy_o,
   output logic             done_o
);

   localparam int unsigned NIBBLES = KEY_W / 4;
   localparam int unsigned NibW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [NibW-1:0] NibLast = NibW'(NIBBLES - 1);

   state_e           state_q;
   logic [KEY_W-1:0] key1_q, key2_q;
   logic             key_sel_q;
   logic [NibW-1:0]  nib_idx_q;
   logic [7:0]       out_data_q;
   logic             out_valid_q;
   logic             out_last_q;
   logic             busy_q;
   logic             done_q;

   logic             hs;
   logic [KEY_W-1:0] cur_key;
   logic [NibW-1:0]  nib_m1;
   logic [3:0]       next_nib;
   logic [7:0]       next_ascii;

   assign hs = out_valid_q & out_if.out_ready;

   // Outputs are registered, so the encoder is fed the nibble that will be on
   // the bus in the next cycle rather than the current one.
   always_comb begin
      cur_key  = key_sel_q ? key2_q : key1_q;
      nib_m1   = nib_idx_q - NibW'(1);
      next_nib = 4'h0;
      unique case (state_q)
         StIdle:  next_nib = key1_i[KEY_W-1 -: 4];
         StHex:   next_nib = cur_key[{nib_m1, 2'b00} +: 4];
         StNl:    next_nib = key2_q[KEY_W-1 -: 4];
         default: next_nib = 4'h0;
      endcase
   end

   hex_ascii_enc u_enc (
      .nib_i   (next_nib),
      .upper_i (UPPERCASE),
      .ascii_o (next_ascii)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         key1_q      <= '0;
         key2_q      <= '0;
         key_sel_q   <= 1'b0;
         nib_idx_q   <= '0;
         out_data_q  <= 8'h00;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  key1_q      <= key1_i;
                  key2_q      <= key2_i;
                  key_sel_q   <= 1'b0;
                  nib_idx_q   <= NibLast;
                  state_q     <= StHex;
                  out_valid_q <= 1'b1;
                  out_data_q  <= next_ascii;
                  out_last_q  <= 1'b0;
                  busy_q      <= 1'b1;
               end
            end
            StHex: begin
               if (hs) begin
                  if (nib_idx_q != '0) begin
                     nib_idx_q  <= nib_m1;
                     out_data_q <= next_ascii;
                  end else begin
                     state_q    <= StNl;
                     out_data_q <= ASCII_NL;
                     out_last_q <= key_sel_q;
                  end
               end
            end
            StNl: begin
               if (hs) begin
                  if (!key_sel_q) begin
                     key_sel_q  <= 1'b1;
                     nib_idx_q  <= NibLast;
                     state_q    <= StHex;
                     out_data_q <= next_ascii;
                     out_last_q <= 1'b0;
                  end else begin
                     state_q     <= StFin;
                     out_valid_q <= 1'b0;
                     out_data_q  <= 8'h00;
                     out_last_q  <= 1'b0;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                  end
               end
            end
            // start is deliberately not looked at here
            StFin: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign out_if.out_data  = out_data_q;
   assign out_if.out_valid = out_valid_q;
   assign out_if.out_last  = out_last_q;
   assign busy_o           = busy_q;
   assign done_o           = done_q;

endmodule

// File: doc/key_hex_writer.md
Name: key_hex_writer

Overview:
- Serialises the two 56-bit DES keys (key1, key2) into the ASCII hex text format the key files use.
- Each key becomes 14 hex characters, MSB nibble first, followed by '\n' (0x0A). key1 is emitted first, then key2.
- The byte stream leaves on a valid/ready interface toward a UART/file-dump path, so keys produced in hardware can be written back out in the same form they are read in.

Parameters:
- KEY_W, 56, key width in bits; must be a multiple of 4.
- UPPERCASE, 0, 0 emits 'a'-'f' (0x61-0x66); 1 emits 'A'-'F' (0x41-0x46).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to emit both keys; sampled only in IDLE.
- key1  input  KEY_W  first key; captured on accepted start.
- key2  input  KEY_W  second key; captured on accepted start.
- out_data  output  8  ASCII byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the byte when out_valid && out_ready.
- out_last  output  1  high with the final byte (key2's newline).
- busy  output  1  high from the cycle after an accepted start until the last byte is accepted.
- done  output  1  one-cycle pulse the cycle after the last byte is accepted.

Behaviour:
- Reset values: all outputs 0; state=IDLE; shadow key registers 0; counters 0.
- Reset asserted mid-stream: immediate abort to IDLE with all outputs 0. No partial resume after reset release.
- States:
  - IDLE: start=1 captures key1/key2 into shadow regs and sets key_sel=0, nib_idx=NIBBLES-1 (NIBBLES=KEY_W/4). Next state is HEX.
  - HEX: out_valid=1 and out_data=ascii(shadow[key_sel][4*nib_idx+:4]).
    - On handshake with nib_idx>0: decrement nib_idx.
    - On handshake with nib_idx==0: go to NL.
  - NL: out_valid=1 and out_data=8'h0A. out_last=1 only when key_sel==1.
    - On handshake with key_sel==0: set key_sel=1, nib_idx=NIBBLES-1, go to HEX.
    - On handshake with key_sel==1: go to FIN.
  - FIN: done=1 for exactly one cycle, busy=0, then go to IDLE.
- Latency:
  - First out_valid appears the cycle after start is sampled.
  - With out_ready held high, one byte transfers per cycle. The total is 2*(NIBBLES+1)=30 bytes.
  - Start accepted at cycle 0 gives bytes accepted at cycles 1..30 and done at cycle 31.
- Handshake rules:
  - While out_valid && !out_ready, out_data and out_last hold stable and out_valid stays high.
  - out_valid, out_data and out_last are functions of registered state only. There is no combinational path from out_ready to any output.
- Nibble-to-ASCII mapping: 0-9 become 0x30-0x39; 10-15 become the letters selected by UPPERCASE.
- Boundary conditions:
  - start while not IDLE (including FIN) is ignored.
  - key1/key2 changes after capture have no effect on the stream.
  - start held high continuously causes back-to-back frames, with IDLE lasting one cycle between them.
  - A start sampled in the same cycle as the done pulse is not accepted.
  - Zero keys emit "00000000000000\n" twice.

Decomposition:
- Shared package des_key_pkg:
  - KEY_W=56
  - ASCII_NL=8'h0A
  - ASCII_0=8'h30, ASCII_LA=8'h61, ASCII_UA=8'h41
  - state enum {IDLE, HEX, NL, FIN}
- One sub-module: hex_ascii_enc, a combinational 4-bit nibble plus UPPERCASE to 8-bit ASCII encoder. It is reusable by a future key_hex_reader.

Test Plan:
1. key1=56'h0123456789ABCD, key2=56'hFEDCBA98765432, UPPERCASE=0, out_ready=1, start pulse at cycle 0 -> bytes "0123456789abcd\nfedcba98765432\n" at cycles 1..30; out_last only on byte 30; done high at cycle 31 only; busy high cycles 1..30.
2. Same keys with out_ready toggling 1,0,0,1 pattern -> identical byte sequence; out_data and out_valid stable during every ready-low cycle; no byte dropped or duplicated.
3. UPPERCASE=1, key1=56'hAAAAAAAAAAAAAA, key2=0 -> 14 bytes 0x41, then 0x0A, then 14 bytes 0x30, then 0x0A.
4. Pulse start again at byte 5, and change key1 to 56'hFFFFFFFFFFFFFF at byte 3 -> stream unchanged from scenario 1; only one done pulse.
5. Assert rst_n=0 after byte 10 of a frame -> all outputs 0 immediately. New start after release -> full 30-byte frame from the first character.
6. start held high for 70 cycles with out_ready=1 -> two complete frames, separated by the FIN and IDLE cycles; a done pulse after each frame.
